// File: rtl/bidir_pattern_tester.sv
// Bring-up tester for a bank of bidirectional pins: drive low, drive high, release,
// read back through a 2-flop synchronizer and log per-channel mismatches.
module bidir_pattern_tester #(
    parameter int CHANNELS        = 4,
    parameter int CLOCKS_PER_STEP = 12000000,
    parameter int SETTLE_CLOCKS   = 4,
    parameter int ERR_WIDTH       = 8,
    localparam int AW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          walk,
    input  logic [CHANNELS-1:0]           channel_mask,
    input  logic [CHANNELS-1:0]           release_expect,
    input  logic                          clear,
    inout  wire  [CHANNELS-1:0]           pins,
    output logic [CHANNELS-1:0]           pin_oe,
    output logic [1:0]                    phase,
    output logic [AW-1:0]                 active,
    output logic                          sample_pulse,
    output logic                          sweep_done,
    output logic [CHANNELS-1:0]           fail,
    output logic [CHANNELS*ERR_WIDTH-1:0] err_count
);

    localparam int CW = $clog2(CLOCKS_PER_STEP);

    typedef enum logic [1:0] {
        PH_IDLE    = 2'd0,
        PH_LOW     = 2'd1,
        PH_HIGH    = 2'd2,
        PH_RELEASE = 2'd3
    } phase_e;

    phase_e                        phase_q, phase_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          walk_q, walk_d;
    logic [AW-1:0]                 active_q, active_d;
    logic [CHANNELS-1:0]           oe_q, oe_d;
    logic [CHANNELS-1:0]           drive_q, drive_d;
    logic [CHANNELS-1:0]           sync1_q, sync2_q;
    logic                          sample_q, sample_d;
    logic                          sweep_q, sweep_d;
    logic [CHANNELS-1:0]           fail_q, fail_d;
    logic [CHANNELS*ERR_WIDTH-1:0] err_q, err_d;

    logic                          step_end_s;
    logic                          release_end_s;
    logic                          sample_now_s;
    logic [CHANNELS-1:0]           expect_s;
    logic [CHANNELS-1:0]           mismatch_s;

    // Pad ring: behavioural equivalent of one BB per channel, T = ~pin_oe.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_pad
        assign pins[g] = oe_q[g] ? drive_q[g] : 1'bz;
    end

    // Phase sequencing, walk latch, active-channel advance and registered pad controls.
    always_comb begin
        phase_d       = phase_q;
        cnt_d         = cnt_q;
        walk_d        = walk_q;
        active_d      = active_q;
        oe_d          = '0;
        drive_d       = '0;
        step_end_s    = (cnt_q == CW'(CLOCKS_PER_STEP - 1));
        release_end_s = (phase_q == PH_RELEASE) && step_end_s;
        sweep_d       = release_end_s && (!walk_q || (active_q == AW'(CHANNELS - 1)));

        if (release_end_s && walk_q) begin
            active_d = (active_q == AW'(CHANNELS - 1)) ? '0 : active_q + AW'(1);
        end else begin
            active_d = active_q;
        end

        if (!enable) begin
            phase_d = PH_IDLE;
            cnt_d   = '0;
        end else begin
            cnt_d = step_end_s ? '0 : cnt_q + CW'(1);
            case (phase_q)
                PH_IDLE: begin
                    phase_d = PH_LOW;
                    cnt_d   = '0;
                    walk_d  = walk;
                end
                PH_LOW:     phase_d = step_end_s ? PH_HIGH : PH_LOW;
                PH_HIGH:    phase_d = step_end_s ? PH_RELEASE : PH_HIGH;
                PH_RELEASE: phase_d = step_end_s ? PH_LOW : PH_RELEASE;
                default: begin
                    phase_d = PH_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Drive decision looks at the upcoming phase so pads switch with phase.
        for (int i = 0; i < CHANNELS; i++) begin
            if ((phase_d == PH_LOW) || (phase_d == PH_HIGH)) begin
                oe_d[i] = channel_mask[i] && (!walk_d || (active_d == AW'(i)));
            end else begin
                oe_d[i] = 1'b0;
            end
            drive_d[i] = (phase_d == PH_HIGH);
        end
    end

    // Readback comparison, saturating error counters and sticky fail flags.
    always_comb begin
        sample_now_s = (phase_q != PH_IDLE) && (cnt_q == CW'(SETTLE_CLOCKS - 1));
        sample_d     = sample_now_s;
        err_d        = err_q;
        for (int i = 0; i < CHANNELS; i++) begin
            expect_s[i]   = oe_q[i] ? drive_q[i] : release_expect[i];
            mismatch_s[i] = sample_now_s && channel_mask[i] && (sync2_q[i] != expect_s[i]);
        end
        if (clear) begin
            err_d  = '0;
            fail_d = '0;
        end else begin
            fail_d = fail_q | mismatch_s;
            for (int i = 0; i < CHANNELS; i++) begin
                if (mismatch_s[i] && (err_q[i*ERR_WIDTH +: ERR_WIDTH] != {ERR_WIDTH{1'b1}})) begin
                    err_d[i*ERR_WIDTH +: ERR_WIDTH] = err_q[i*ERR_WIDTH +: ERR_WIDTH] + ERR_WIDTH'(1);
                end else begin
                    err_d[i*ERR_WIDTH +: ERR_WIDTH] = err_q[i*ERR_WIDTH +: ERR_WIDTH];
                end
            end
        end
    end

    // State, pad control, synchronizer and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= '0;
            walk_q   <= 1'b0;
            active_q <= '0;
            oe_q     <= '0;
            drive_q  <= '0;
            sync1_q  <= '0;
            sync2_q  <= '0;
            sample_q <= 1'b0;
            sweep_q  <= 1'b0;
            fail_q   <= '0;
            err_q    <= '0;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            walk_q   <= walk_d;
            active_q <= active_d;
            oe_q     <= oe_d;
            drive_q  <= drive_d;
            sync1_q  <= pins;
            sync2_q  <= sync1_q;
            sample_q <= sample_d;
            sweep_q  <= sweep_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
        end
    end

    assign pin_oe       = oe_q;
    assign phase        = phase_q;
    assign active       = active_q;
    assign sample_pulse = sample_q;
    assign sweep_done   = sweep_q;
    assign fail         = fail_q;
    assign err_count    = err_q;

endmodule

// File: doc/bidir_pattern_tester.md
# bidir_pattern_tester

Parametrised bring-up tester for a bank of bidirectional FPGA pins. Per phase it drives each enabled pin low, then high, then releases it, and reads every pin back through a synchronizer. Per-channel error counters and sticky fail flags record mismatches. A walk mode drives one channel at a time while checking the released neighbours, which catches pin-to-pin shorts. It sits at the top level during board bring-up, between the pad ring (one `BB` primitive per channel) and status LEDs/debug headers.

## Interface
- `CHANNELS`, 4: number of bidirectional pins under test (1..32).
- `CLOCKS_PER_STEP`, 12000000: clocks per phase.
- `SETTLE_CLOCKS`, 4: clocks after phase start before readback is sampled. Must satisfy 3 ≤ `SETTLE_CLOCKS` < `CLOCKS_PER_STEP`.
- `ERR_WIDTH`, 8: width of each saturating error counter.

- `clock` in 1: system clock.
- `reset_n` in 1: asynchronous active-low reset.
- `enable` in 1: run the test; low returns to IDLE.
- `walk` in 1: 0 = all channels in parallel, 1 = walking single channel.
- `channel_mask` in CHANNELS: 1 = channel participates.
- `release_expect` in CHANNELS: expected level on a released pin (pull-up = 1).
- `clear` in 1: synchronous clear of counters and fail flags.
- `pins` inout CHANNELS: pads, one `BB` per channel (T = ~pin_oe[i]).
- `pin_oe` out CHANNELS: current output enables.
- `phase` out 2: 0 IDLE, 1 DRIVE_LOW, 2 DRIVE_HIGH, 3 RELEASE.
- `active` out clog2(CHANNELS) (min 1): walk-mode channel index.
- `sample_pulse` out 1: one-cycle strobe, counters updated.
- `sweep_done` out 1: one-cycle strobe at end of full sweep.
- `fail` out CHANNELS: sticky per-channel mismatch flag.
- `err_count` out CHANNELS*ERR_WIDTH: channel i at bits [i*ERR_WIDTH +: ERR_WIDTH].

## Operation
- FSM transitions: IDLE → DRIVE_LOW when `enable`=1; DRIVE_LOW → DRIVE_HIGH → RELEASE → DRIVE_LOW, each after `CLOCKS_PER_STEP` clocks.
- `enable`=0 in any state → IDLE on the next clock. In IDLE all pins are released, counters hold, `active` holds, and `walk` is latched on the IDLE→DRIVE_LOW edge. Mid-run changes to `walk` are ignored.
- Drive rules:
  - Parallel mode, DRIVE phases: every masked-in channel is driven (0 in DRIVE_LOW, 1 in DRIVE_HIGH).
  - Walk mode, DRIVE phases: only channel `active` is driven, and only if masked-in.
  - RELEASE: all channels released.
  - Masked-out channels are never driven.
- Expected value per channel: a driven channel expects its drive value; a released channel expects `release_expect[i]`.
- Readback: each pin passes through a 2-flop synchronizer. The comparison uses synchronizer output in the cycle where phase counter == `SETTLE_CLOCKS`-1. A masked-out channel never counts.
- On mismatch: `err_count[i]` increments, saturating at 2^ERR_WIDTH-1, and `fail[i]` is set.
- `clear` zeroes all counters and flags. It has priority over a coincident increment.
- `active` advances modulo `CHANNELS` at the end of each RELEASE phase in walk mode, wrapping CHANNELS-1 → 0.
- `sweep_done` fires at the end of RELEASE when walk=0, or when walk=1 and `active`==CHANNELS-1.

## Timing
- Reset (asynchronous, immediate): `phase`=0, `pin_oe`=0, `active`=0, `fail`=0, `err_count`=0, strobes 0, synchronizers 0.
- Pin drive and `pin_oe` are registered. They change on the same edge as `phase`.
- Sample latency: pin level → synchronized 2 clocks later. Counter/`fail` update on the edge closing the sample cycle. `sample_pulse` is high in the cycle after that edge, exactly once per phase.
- Phase length is exactly `CLOCKS_PER_STEP` cycles. Parallel sweep = 3×CLOCKS_PER_STEP. Walk sweep = 3×CHANNELS×CLOCKS_PER_STEP.
- `sweep_done` is high in the first cycle of the following DRIVE_LOW, or of IDLE if `enable` dropped.

## Test plan
Bench: CHANNELS=4, CLOCKS_PER_STEP=16, SETTLE_CLOCKS=4, ERR_WIDTH=4; weak pull-ups on all pins; `release_expect`=4'hF; `channel_mask`=4'hF.
- Reset/idle: `reset_n` low, then high with `enable`=0 for 100 clocks → `phase`=0, `pin_oe`=0, `err_count`=0, no strobes.
- Clean parallel run: `enable`=1, `walk`=0 → phases 1/2/3 each 16 clocks; `pin_oe`=4'hF in phases 1–2, 0 in phase 3; `sample_pulse` once per phase; `sweep_done` every 48 clocks; `fail`=0.
- Release fault: pin1 weak pull-down, release_expect=4'hF, run 3 sweeps → `err_count` ch1=3, others 0; `fail`=4'b0010.
- Short in walk mode: pins 0 and 3 shorted, `walk`=1, one sweep (192 clocks) → ch3 error when active=0 DRIVE_LOW, ch0 error when active=3 DRIVE_LOW; `err_count` ch0=1, ch3=1; `sweep_done` once; `active` back to 0.
- Saturation/clear: release fault for 20 sweeps → ch1 holds 15. Pulse `clear` coincident with `sample_pulse` edge → ch1=0, `fail`=0 next cycle.
- Reset mid-operation: assert `reset_n` during DRIVE_HIGH → `pin_oe`=0 and `phase`=0 immediately, without waiting for a clock edge. After release, restart from DRIVE_LOW with `active`=0.
